// File: rtl/board_move_ctrl.sv
// Command sequencer and bus arbiter for the 64-square board register file.
// Runs read-modify-write board operations and passes CPU accesses through when idle.
module board_move_ctrl #(
  parameter int NSQ = 64
) (
  input  logic       CLK,
  input  logic       RESET_N,
  // CPU-side Avalon-MM slave
  input  logic       CPU_CS,
  input  logic       CPU_READ,
  input  logic       CPU_WRITE,
  input  logic [5:0] CPU_ADDR,
  input  logic [7:0] CPU_WRITEDATA,
  output logic [7:0] CPU_READDATA,
  output logic       CPU_WAITREQ,
  // Command port
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [1:0] CMD_OP,
  input  logic [5:0] CMD_SRC,
  input  logic [5:0] CMD_DST,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  // Board-side Avalon-MM master
  output logic       BRD_CS,
  output logic       BRD_READ,
  output logic       BRD_WRITE,
  output logic [5:0] BRD_ADDR,
  output logic [7:0] BRD_WRITEDATA,
  input  logic [7:0] BRD_READDATA,
  // Sequencer state, for observation only
  output logic [2:0] DBG_STATE
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD    = 3'd1;
  localparam logic [2:0] S_RWAIT = 3'd2;
  localparam logic [2:0] S_WR1   = 3'd3;
  localparam logic [2:0] S_WR2   = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_MOVE  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_HLSET = 2'b11;

  localparam logic [5:0] LAST_IDX = 6'(NSQ - 1);

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic [1:0] r_op;
  logic [5:0] r_src;
  logic [5:0] r_dst;
  logic [5:0] r_idx;
  logic [3:0] r_piece;
  logic       r_err;

  logic w_idle;
  logic w_cpu_req;
  logic w_accept;
  logic w_same_sq;
  logic w_empty;
  logic w_last;

  // Handshake: a command transfers on the CLK edge where CMD_VALID && CMD_READY.
  // READY is only offered in IDLE with no CPU request pending (CPU wins ties),
  // and never while RESET_N is low.
  assign w_idle    = (r_state == S_IDLE);
  assign w_cpu_req = CPU_CS && (CPU_READ || CPU_WRITE);
  assign CMD_READY = RESET_N && w_idle && !w_cpu_req;
  assign w_accept  = CMD_VALID && CMD_READY;
  assign w_same_sq = (CMD_SRC == CMD_DST);
  assign w_empty   = (BRD_READDATA[3:0] == 4'd0);
  assign w_last    = (r_idx == LAST_IDX);

  assign BUSY         = !w_idle;
  assign DONE         = (r_state == S_FIN);
  assign ERR          = r_err;
  assign CPU_WAITREQ  = !w_idle && w_cpu_req;
  assign CPU_READDATA = BRD_READDATA;
  assign DBG_STATE    = r_state;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (CMD_OP)
            OP_NOP:  w_next = S_FIN;
            OP_MOVE: w_next = w_same_sq ? S_FIN : S_RD;
            default: w_next = S_RD;
          endcase
        end
      end
      S_RD:    w_next = S_RWAIT;
      S_RWAIT: w_next = ((r_op == OP_MOVE) && w_empty) ? S_FIN : S_WR1;
      S_WR1: begin
        case (r_op)
          OP_MOVE:  w_next = S_WR2;
          OP_CLEAR: w_next = w_last ? S_FIN : S_RD;
          default:  w_next = S_FIN;
        endcase
      end
      S_WR2:   w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
      r_op    <= OP_NOP;
      r_src   <= 6'd0;
      r_dst   <= 6'd0;
      r_idx   <= 6'd0;
      r_piece <= 4'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_idle && w_accept) begin
        r_op  <= CMD_OP;
        r_src <= CMD_SRC;
        r_dst <= CMD_DST;
        r_idx <= 6'd0;
        // A same-square move fails without touching the board.
        r_err <= (CMD_OP == OP_MOVE) && w_same_sq;
      end
      if (r_state == S_RWAIT) begin
        r_piece <= BRD_READDATA[3:0];
        if ((r_op == OP_MOVE) && w_empty) begin
          r_err <= 1'b1;
        end
      end
      if ((r_state == S_WR1) && (r_op == OP_CLEAR) && !w_last) begin
        r_idx <= r_idx + 6'd1;
      end
    end
  end

  always_comb begin
    BRD_CS        = 1'b0;
    BRD_READ      = 1'b0;
    BRD_WRITE     = 1'b0;
    BRD_ADDR      = 6'd0;
    BRD_WRITEDATA = 8'd0;
    case (r_state)
      S_IDLE: begin
        if (RESET_N) begin
          BRD_CS        = CPU_CS;
          BRD_READ      = CPU_READ;
          BRD_WRITE     = CPU_WRITE;
          BRD_ADDR      = CPU_ADDR;
          BRD_WRITEDATA = CPU_WRITEDATA;
        end
      end
      S_RD: begin
        BRD_CS   = 1'b1;
        BRD_READ = 1'b1;
        BRD_ADDR = (r_op == OP_CLEAR) ? r_idx : r_src;
      end
      S_WR1: begin
        BRD_CS    = 1'b1;
        BRD_WRITE = 1'b1;
        case (r_op)
          OP_MOVE: begin
            BRD_ADDR      = r_dst;
            BRD_WRITEDATA = {3'b000, 1'b1, r_piece};
          end
          OP_CLEAR: begin
            BRD_ADDR      = r_idx;
            BRD_WRITEDATA = {4'b0000, r_piece};
          end
          default: begin
            BRD_ADDR      = r_src;
            BRD_WRITEDATA = {3'b000, 1'b1, r_piece};
          end
        endcase
      end
      S_WR2: begin
        // Vacated source square is left empty but highlighted.
        BRD_CS        = 1'b1;
        BRD_WRITE     = 1'b1;
        BRD_ADDR      = r_src;
        BRD_WRITEDATA = 8'h10;
      end
      default: begin
        BRD_CS = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_board_move_ctrl.sv
// Bench for board_move_ctrl: behavioural board memory, a square-level reference
// model of each command, and per-scenario checks.
module tb_board_move_ctrl;

  localparam int NSQ = 64;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       CPU_CS, CPU_READ, CPU_WRITE;
  logic [5:0] CPU_ADDR;
  logic [7:0] CPU_WRITEDATA;
  logic [7:0] CPU_READDATA;
  logic       CPU_WAITREQ;
  logic       CMD_VALID, CMD_READY;
  logic [1:0] CMD_OP;
  logic [5:0] CMD_SRC, CMD_DST;
  logic       BUSY, DONE, ERR;
  logic       BRD_CS, BRD_READ, BRD_WRITE;
  logic [5:0] BRD_ADDR;
  logic [7:0] BRD_WRITEDATA;
  logic [7:0] BRD_READDATA;
  logic [2:0] DBG_STATE;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem[NSQ];
  logic [7:0]  init_img[NSQ];
  logic [7:0]  ref_mem[NSQ];
  logic        load_img = 1'b0;
  logic [15:0] log_q[$];
  logic [15:0] exp_q[$];

  always #5 CLK = ~CLK;

  board_move_ctrl #(.NSQ(NSQ)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .CPU_CS(CPU_CS), .CPU_READ(CPU_READ), .CPU_WRITE(CPU_WRITE),
    .CPU_ADDR(CPU_ADDR), .CPU_WRITEDATA(CPU_WRITEDATA),
    .CPU_READDATA(CPU_READDATA), .CPU_WAITREQ(CPU_WAITREQ),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
    .CMD_SRC(CMD_SRC), .CMD_DST(CMD_DST),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .BRD_CS(BRD_CS), .BRD_READ(BRD_READ), .BRD_WRITE(BRD_WRITE),
    .BRD_ADDR(BRD_ADDR), .BRD_WRITEDATA(BRD_WRITEDATA),
    .BRD_READDATA(BRD_READDATA), .DBG_STATE(DBG_STATE)
  );

  // Board register file: registered read, no reset; load_img preloads contents.
  always @(posedge CLK) begin
    if (load_img) begin
      for (int i = 0; i < NSQ; i++) mem[i] <= init_img[i];
    end else begin
      if (BRD_CS && BRD_WRITE) mem[BRD_ADDR] <= BRD_WRITEDATA;
      if (BRD_CS && BRD_READ) BRD_READDATA <= mem[BRD_ADDR];
    end
  end

  // Access log {write, read, addr, data}; read entries carry zero data.
  always @(negedge CLK) begin
    if (RESET_N && BRD_CS)
      log_q.push_back({BRD_WRITE, BRD_READ, BRD_ADDR, BRD_READ ? 8'h00 : BRD_WRITEDATA});
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_board();
    load_img = 1'b1;
    tick();
    load_img = 1'b0;
    for (int i = 0; i < NSQ; i++) ref_mem[i] = init_img[i];
  endtask

  task automatic random_image();
    for (int i = 0; i < NSQ; i++)
      init_img[i] = {3'b000, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15))};
  endtask

  // Square-level effect of one command: expected accesses, busy length and error.
  task automatic model_cmd(input logic [1:0] op, input logic [5:0] s, input logic [5:0] d,
                           output int busy, output logic err);
    logic [3:0] p;
    exp_q.delete();
    err  = 1'b0;
    busy = 1;
    case (op)
      2'b01: begin
        if (s == d) begin
          err = 1'b1;
        end else begin
          exp_q.push_back({2'b01, s, 8'h00});
          p = ref_mem[s][3:0];
          if (p == 4'd0) begin
            busy = 3;
            err  = 1'b1;
          end else begin
            exp_q.push_back({2'b10, d, 4'b0001, p});
            exp_q.push_back({2'b10, s, 8'h10});
            ref_mem[d] = {4'b0001, p};
            ref_mem[s] = 8'h10;
            busy = 5;
          end
        end
      end
      2'b11: begin
        p = ref_mem[s][3:0];
        exp_q.push_back({2'b01, s, 8'h00});
        exp_q.push_back({2'b10, s, 4'b0001, p});
        ref_mem[s] = {4'b0001, p};
        busy = 4;
      end
      2'b10: begin
        for (int i = 0; i < NSQ; i++) begin
          p = ref_mem[i][3:0];
          exp_q.push_back({2'b01, 6'(i), 8'h00});
          exp_q.push_back({2'b10, 6'(i), 4'b0000, p});
          ref_mem[i] = {4'b0000, p};
        end
        busy = 3 * NSQ + 1;
      end
      default: busy = 1;
    endcase
  endtask

  // Issues one command, runs it to completion and checks timing, flags, accesses and board.
  task automatic do_cmd(input string name, input logic [1:0] op, input logic [5:0] s,
                        input logic [5:0] d);
    int exp_busy, cnt, done_cnt, done_at, base, n, mism, bm;
    logic exp_err;
    bit timeout;
    model_cmd(op, s, d, exp_busy, exp_err);
    base = log_q.size();
    CMD_VALID = 1'b1; CMD_OP = op; CMD_SRC = s; CMD_DST = d;
    @(negedge CLK);
    total++;
    if (CMD_READY !== 1'b1) begin
      bad++; $display("FAIL %s ready: got %b want 1", name, CMD_READY);
    end
    tick();
    CMD_VALID = 1'b0; CMD_OP = 2'b00;
    cnt = 0; done_cnt = 0; done_at = -1; timeout = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      if (!BUSY) begin timeout = 1'b0; break; end
      cnt++;
      if (DONE) begin done_cnt++; done_at = cnt; end
    end
    total++;
    if (timeout || cnt != exp_busy) begin
      bad++; $display("FAIL %s busy_cycles: got %0d want %0d (timeout=%0b)", name, cnt, exp_busy, timeout);
    end
    total++;
    if (done_cnt != 1 || done_at != cnt) begin
      bad++; $display("FAIL %s done_pulse: got count %0d at cycle %0d want 1 at %0d", name, done_cnt, done_at, cnt);
    end
    total++;
    if (ERR !== exp_err) begin
      bad++; $display("FAIL %s err: got %b want %b", name, ERR, exp_err);
    end
    n = log_q.size() - base;
    total++;
    if (n != exp_q.size()) begin
      bad++; $display("FAIL %s access_count: got %0d want %0d", name, n, exp_q.size());
    end
    mism = -1;
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      if (log_q[base + i] !== exp_q[i]) begin mism = i; break; end
    end
    total++;
    if (mism >= 0) begin
      bad++; $display("FAIL %s access[%0d]: got %h want %h", name, mism, log_q[base + mism], exp_q[mism]);
    end
    bm = -1;
    for (int i = 0; i < NSQ; i++) if (mem[i] !== ref_mem[i]) begin bm = i; break; end
    total++;
    if (bm >= 0) begin
      bad++; $display("FAIL %s board[%0d]: got %h want %h", name, bm, mem[bm], ref_mem[bm]);
    end
    tick();
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    CPU_CS = 1'b0; CPU_READ = 1'b0; CPU_WRITE = 1'b0; CPU_ADDR = 6'd0; CPU_WRITEDATA = 8'd0;
    CMD_VALID = 1'b1; CMD_OP = 2'b01; CMD_SRC = 6'd1; CMD_DST = 6'd2;
    repeat (3) @(negedge CLK);
    total++;
    if ({BUSY, DONE, ERR, CMD_READY, CPU_WAITREQ} !== 5'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 00000", {BUSY, DONE, ERR, CMD_READY, CPU_WAITREQ});
    end
    total++;
    if ({BRD_CS, BRD_READ, BRD_WRITE, BRD_ADDR, BRD_WRITEDATA} !== 17'd0) begin
      bad++; $display("FAIL reset_brd: got %h want 0", {BRD_CS, BRD_READ, BRD_WRITE, BRD_ADDR, BRD_WRITEDATA});
    end
    CMD_VALID = 1'b0; CMD_OP = 2'b00;
    tick();
    RESET_N = 1'b1;
    random_image();
    load_board();
    @(negedge CLK);
    total++;
    if (BUSY !== 1'b0 || CMD_READY !== 1'b1) begin
      bad++; $display("FAIL post_reset_idle: got busy=%b ready=%b want busy=0 ready=1", BUSY, CMD_READY);
    end
    tick();
  endtask

  task automatic test_cpu_idle();
    int wr_hi = 0;
    CPU_CS = 1'b1; CPU_WRITE = 1'b1; CPU_ADDR = 6'd5; CPU_WRITEDATA = 8'h03;
    @(negedge CLK); if (CPU_WAITREQ) wr_hi++;
    tick();
    ref_mem[5] = 8'h03;
    CPU_WRITE = 1'b0; CPU_READ = 1'b1;
    @(negedge CLK); if (CPU_WAITREQ) wr_hi++;
    tick();
    CPU_CS = 1'b0; CPU_READ = 1'b0;
    @(negedge CLK);
    total++;
    if (CPU_READDATA !== 8'h03) begin
      bad++; $display("FAIL cpu_idle_read: got %h want 03", CPU_READDATA);
    end
    total++;
    if (wr_hi != 0) begin
      bad++; $display("FAIL cpu_idle_waitreq: got %0d high cycles want 0", wr_hi);
    end
    tick();
  endtask

  task automatic test_move();
    for (int i = 0; i < NSQ; i++) init_img[i] = ref_mem[i];
    init_img[12] = 8'h04;
    load_board();
    do_cmd("move_12_28", 2'b01, 6'd12, 6'd28);
  endtask

  task automatic test_move_err();
    for (int i = 0; i < NSQ; i++) init_img[i] = ref_mem[i];
    init_img[20] = 8'h10;
    load_board();
    do_cmd("move_empty", 2'b01, 6'd20, 6'd3);
    do_cmd("move_same", 2'b01, 6'd7, 6'd7);
    do_cmd("nop", 2'b00, 6'd0, 6'd0);
  endtask

  task automatic test_hl_set();
    for (int k = 0; k < 3; k++) do_cmd("hl_set", 2'b11, 6'($urandom_range(0, NSQ - 1)), 6'd0);
  endtask

  task automatic test_clear_hl();
    for (int i = 0; i < NSQ; i++) init_img[i] = 8'h1A;
    load_board();
    do_cmd("clear_hl", 2'b10, 6'd0, 6'd0);
  endtask

  task automatic test_cpu_during_busy();
    int exp_busy, cnt, wbad;
    logic exp_err;
    logic [5:0] a;
    bit timeout;
    random_image();
    load_board();
    a = 6'($urandom_range(0, NSQ - 1));
    model_cmd(2'b10, 6'd0, 6'd0, exp_busy, exp_err);
    CMD_VALID = 1'b1; CMD_OP = 2'b10;
    @(negedge CLK);
    tick();
    CMD_VALID = 1'b0;
    cnt = 0; wbad = 0; timeout = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      if (!BUSY) begin timeout = 1'b0; break; end
      cnt++;
      if (cnt > 10 && !CPU_WAITREQ) wbad++;
      if (cnt == 10) begin
        tick();
        CPU_CS = 1'b1; CPU_READ = 1'b1; CPU_ADDR = a;
        CMD_VALID = 1'b1; CMD_OP = 2'b00;
      end
    end
    total++;
    if (timeout || cnt != exp_busy) begin
      bad++; $display("FAIL busy_cpu_cycles: got %0d want %0d", cnt, exp_busy);
    end
    total++;
    if (wbad != 0) begin
      bad++; $display("FAIL busy_cpu_waitreq: got %0d low cycles want 0", wbad);
    end
    total++;
    if ({CPU_WAITREQ, CMD_READY, BRD_CS, BRD_READ, BRD_ADDR} !== {4'b0011, a}) begin
      bad++; $display("FAIL busy_cpu_passthru: got %b want %b", {CPU_WAITREQ, CMD_READY, BRD_CS, BRD_READ, BRD_ADDR}, {4'b0011, a});
    end
    tick();
    CPU_CS = 1'b0; CPU_READ = 1'b0; CMD_VALID = 1'b0;
    @(negedge CLK);
    total++;
    if (CPU_READDATA !== ref_mem[a]) begin
      bad++; $display("FAIL busy_cpu_rdata: got %h want %h", CPU_READDATA, ref_mem[a]);
    end
    tick();
  endtask

  task automatic test_cpu_priority();
    logic [5:0] a;
    logic [7:0] d;
    a = 6'($urandom_range(0, NSQ - 1));
    d = {4'b0000, 4'($urandom_range(1, 15))};
    CPU_CS = 1'b1; CPU_WRITE = 1'b1; CPU_ADDR = a; CPU_WRITEDATA = d;
    CMD_VALID = 1'b1; CMD_OP = 2'b11; CMD_SRC = a;
    @(negedge CLK);
    total++;
    if ({CMD_READY, BRD_WRITE, BRD_ADDR} !== {2'b01, a}) begin
      bad++; $display("FAIL prio_ready: got %b want %b", {CMD_READY, BRD_WRITE, BRD_ADDR}, {2'b01, a});
    end
    tick();
    CPU_CS = 1'b0; CPU_WRITE = 1'b0;
    ref_mem[a] = d;
    do_cmd("prio_hl_set", 2'b11, a, 6'd0);
  endtask

  task automatic test_reset_mid_move();
    for (int i = 0; i < NSQ; i++) init_img[i] = ref_mem[i];
    init_img[12] = 8'h04; init_img[28] = 8'h00;
    load_board();
    CMD_VALID = 1'b1; CMD_OP = 2'b01; CMD_SRC = 6'd12; CMD_DST = 6'd28;
    @(negedge CLK);
    tick();
    CMD_VALID = 1'b0; CMD_OP = 2'b00;
    repeat (3) @(negedge CLK);
    tick();
    RESET_N = 1'b0;
    #1;
    total++;
    if ({BUSY, DONE, BRD_CS, BRD_WRITE} !== 4'b0000) begin
      bad++; $display("FAIL mid_reset_outputs: got %b want 0000", {BUSY, DONE, BRD_CS, BRD_WRITE});
    end
    @(negedge CLK);
    total++;
    if (mem[28] !== 8'h14 || mem[12] !== 8'h04) begin
      bad++; $display("FAIL mid_reset_board: got 28=%h 12=%h want 28=14 12=04", mem[28], mem[12]);
    end
    tick();
    RESET_N = 1'b1;
    ref_mem[28] = 8'h14;
    tick();
  endtask

  task automatic test_random();
    logic [5:0] s, d;
    for (int k = 0; k < 25; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        random_image();
        load_board();
      end
      s = 6'($urandom_range(0, NSQ - 1));
      d = ($urandom_range(0, 3) == 0) ? s : 6'($urandom_range(0, NSQ - 1));
      do_cmd("random", 2'($urandom_range(0, 3)), s, d);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_idle();
    test_move();
    test_move_err();
    test_hl_set();
    test_clear_hl();
    test_cpu_during_busy();
    test_cpu_priority();
    test_reset_mid_move();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
